tmds_encoder: RTL and testbench

TMDS_ENCODER -- requirements
Module: tmds_encoder

---
 rtl/tmds_encoder.sv | 125 ++++++++++++
 tb/tb_tmds_encoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - 8b/10b TMDS symbol encoder, two-stage pipeline.
// Optional running-disparity balancing is enabled by defining TMDS_DC_BALANCE_EN.
module tmds_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_en,
    input  logic       c0,
    input  logic       c1,
    input  logic [7:0] data,
    output logic [9:0] tmds
);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimising stage: XNOR chain when the byte is 1-heavy.
    function automatic logic [8:0] minimise(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n1;
        logic       use_xnor;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = !use_xnor;
        return q;
    endfunction

    logic       en_q;
    logic [1:0] ctl_q;
    logic [8:0] qm_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q  <= 1'b0;
            ctl_q <= 2'b00;
            qm_q  <= 9'd0;
        end else begin
            en_q  <= data_en;
            ctl_q <= {c1, c0};
            qm_q  <= minimise(data);
        end
    end

    logic [9:0] ctl_code;

    always_comb begin
        ctl_code = 10'h354;
        case (ctl_q)
            2'b00: ctl_code = 10'h354;
            2'b01: ctl_code = 10'h0AB;
            2'b10: ctl_code = 10'h154;
            2'b11: ctl_code = 10'h2AB;
            default: ctl_code = 10'h354;
        endcase
    end

`ifdef TMDS_DC_BALANCE_EN
    logic [4:0]        cnt;
    logic [4:0]        cnt_nxt;
    logic [9:0]        sym;
    logic signed [5:0] diff;
    logic signed [5:0] delta;
    logic signed [5:0] sum;
    logic              cnt_pos;
    logic              cnt_neg;
    logic              diff_pos;
    logic              diff_neg;

    // diff = N1 - N0 = 2*N1 - 8, always in -8..+8
    always_comb begin
        diff     = $signed({1'b0, popcount8(qm_q[7:0]), 1'b0}) - 6'sd8;
        cnt_neg  = cnt[4];
        cnt_pos  = !cnt[4] && (cnt != 5'd0);
        diff_neg = diff[5];
        diff_pos = !diff[5] && (diff != 6'sd0);
        sym      = {1'b0, qm_q[8], qm_q[7:0]};
        delta    = 6'sd0;
        if ((cnt == 5'd0) || (diff == 6'sd0)) begin
            sym   = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            delta = qm_q[8] ? diff : -diff;
        end else if ((cnt_pos && diff_pos) || (cnt_neg && diff_neg)) begin
            sym   = {1'b1, qm_q[8], ~qm_q[7:0]};
            delta = (qm_q[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
            sym   = {1'b0, qm_q[8], qm_q[7:0]};
            delta = diff - (qm_q[8] ? 6'sd0 : 6'sd2);
        end
        sum     = $signed({cnt[4], cnt}) + delta;
        cnt_nxt = sum[4:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= 5'd0;
            tmds <= 10'h354;
        end else if (en_q) begin
            cnt  <= cnt_nxt;
            tmds <= sym;
        end else begin
            cnt  <= 5'd0;
            tmds <= ctl_code;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            tmds <= 10'h354;
        end else if (en_q) begin
            tmds <= {1'b0, qm_q[8], qm_q[7:0]};
        end else begin
            tmds <= ctl_code;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// tb/tb_tmds_encoder.sv - table and scoreboard bench for tmds_encoder.
module tb_tmds_encoder;

`ifdef TMDS_DC_BALANCE_EN
    localparam bit DC = 1'b1;
`else
    localparam bit DC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       data_en;
    logic       c0;
    logic       c1;
    logic [7:0] data;
    logic [9:0] tmds;

    always #5 clk = ~clk;

    tmds_encoder dut (
        .clk     (clk),
        .reset   (reset),
        .data_en (data_en),
        .c0      (c0),
        .c1      (c1),
        .data    (data),
        .tmds    (tmds)
    );

    typedef struct {
        logic       en;
        logic [1:0] c;
        logic [7:0] d;
        logic [9:0] exp_dc;
        logic [9:0] exp_plain;
        string      name;
    } vec_t;

    vec_t       vec [12];
    logic [9:0] exp_q [$];
    string      name_q [$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         mcnt = 0;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: tmds=0x%03h expected 0x%03h", name, act, exp);
        end
    endtask

    // Reference encoder; keeps its own running disparity in mcnt.
    function automatic logic [9:0] model(input logic en, input logic [1:0] c, input logic [7:0] d);
        logic [8:0] qm;
        int         ones;
        int         n1;
        int         n0;
        logic       xn;
        logic [9:0] r;
        if (!en) begin
            mcnt = 0;
            case (c)
                2'b00: r = 10'h354;
                2'b01: r = 10'h0AB;
                2'b10: r = 10'h154;
                default: r = 10'h2AB;
            endcase
            return r;
        end
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~xn;
        if (!DC) return {1'b0, qm};
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
        n0 = 8 - n1;
        if (mcnt == 0 || n1 == n0) begin
            r = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            mcnt += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
            r = {1'b1, qm[8], ~qm[7:0]};
            mcnt += 2 * int'(qm[8]) + (n0 - n1);
        end else begin
            r = {1'b0, qm[8], qm[7:0]};
            mcnt += (n1 - n0) - 2 * int'(~qm[8]);
        end
        return r;
    endfunction

    task automatic drive(input logic en, input logic [1:0] c, input logic [7:0] d,
                         input logic [9:0] exp, input string name);
        data_en = en;
        {c1, c0} = c;
        data = d;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        if (exp_q.size() > 1) check(name_q.pop_front(), tmds, exp_q.pop_front());
    endtask

    task automatic drive_model(input logic en, input logic [1:0] c, input logic [7:0] d,
                               input string name);
        logic [9:0] e;
        e = model(en, c, d);
        drive(en, c, d, e, name);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check("reset_state", tmds, 10'h354);
        end
        reset = 1'b0;
        exp_q.delete();
        name_q.delete();
        exp_q.push_back(10'h354);
        name_q.push_back("post_reset_blank");
        mcnt = 0;
    endtask

    initial begin
        vec[0]  = '{1'b0, 2'b00, 8'h00, 10'h354, 10'h354, "ctl00"};
        vec[1]  = '{1'b0, 2'b01, 8'h00, 10'h0AB, 10'h0AB, "ctl01"};
        vec[2]  = '{1'b0, 2'b10, 8'h00, 10'h154, 10'h154, "ctl10"};
        vec[3]  = '{1'b0, 2'b11, 8'h00, 10'h2AB, 10'h2AB, "ctl11"};
        vec[4]  = '{1'b1, 2'b00, 8'h00, 10'h100, 10'h100, "zero_1"};
        vec[5]  = '{1'b1, 2'b00, 8'h00, 10'h3FF, 10'h100, "zero_2"};
        vec[6]  = '{1'b1, 2'b00, 8'h00, 10'h100, 10'h100, "zero_3"};
        vec[7]  = '{1'b0, 2'b00, 8'h00, 10'h354, 10'h354, "blank_after_zero"};
        vec[8]  = '{1'b1, 2'b00, 8'hFF, 10'h200, 10'h0FF, "ones_from_0"};
        vec[9]  = '{1'b0, 2'b11, 8'h00, 10'h2AB, 10'h2AB, "blank_after_ones"};
        vec[10] = '{1'b1, 2'b00, 8'h01, 10'h1FF, 10'h1FF, "one_bit_1"};
        vec[11] = '{1'b1, 2'b00, 8'h01, 10'h300, 10'h1FF, "one_bit_2"};

        reset = 1'b1;
        data_en = 1'b0;
        c0 = 1'b0;
        c1 = 1'b0;
        data = 8'h00;
        do_reset(3);

        for (int i = 0; i < 12; i++) begin
            void'(model(vec[i].en, vec[i].c, vec[i].d));
            drive(vec[i].en, vec[i].c, vec[i].d, DC ? vec[i].exp_dc : vec[i].exp_plain, vec[i].name);
        end

        for (int i = 0; i < 150; i++) begin
            drive_model(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                        8'($urandom_range(0, 255)), "random");
        end

        // Reset in the middle of an active line; in-flight symbols are dropped.
        drive_model(1'b1, 2'b00, 8'h5A, "pre_reset_a");
        drive_model(1'b1, 2'b00, 8'hC3, "pre_reset_b");
        do_reset(1);
        drive_model(1'b1, 2'b00, 8'h00, "post_reset_first");
        drive_model(1'b1, 2'b00, 8'h00, "post_reset_second");
        drive_model(1'b1, 2'b00, 8'hFF, "post_reset_third");
        for (int i = 0; i < 60; i++) begin
            drive_model(1'b1, 2'b00, 8'($urandom_range(0, 255)), "random_active");
        end

        drive_model(1'b0, 2'b00, 8'h00, "drain_a");
        drive_model(1'b0, 2'b01, 8'h00, "drain_b");
        drive_model(1'b0, 2'b00, 8'h00, "drain_c");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
